// File: rtl/tdm_slot_mux_pkg.sv
// Shared definitions for the ring-sequenced TDM slot multiplexer.
package ring_pkg;

  localparam int unsigned DefNch = 4;
  localparam int unsigned DefDw  = 8;
  localparam int unsigned DefCw  = $clog2(DefNch);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // True when exactly one bit of the (zero-extended) slot vector is set.
  function automatic logic onehot_ok(logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Binary index of the set bit; only meaningful when onehot_ok() holds.
  function automatic logic [4:0] onehot2bin(logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tdm_slot_mux_if.sv
// Requester and sink handshake bundle for tdm_slot_mux.
interface tdm_slot_mux_if
  import ring_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned NCH = DefNch
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_ready;

  // Drives requests and the downstream ready (testbench / system side).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  // The multiplexer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/tdm_slot_mux_chan_hold.sv
// Single-entry holding register for one requester channel.
module chan_hold
  import ring_pkg::*;
#(
  parameter int unsigned DW = DefDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          clr,
  output logic          full,
  output logic [DW-1:0] data
);

  logic          full_q;
  logic [DW-1:0] data_q;

  // Capture when empty; clear when granted. The two are exclusive since a grant needs full_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (clr) begin
      full_q <= 1'b0;
    end
  end

  // Ready comes from registered state only.
  assign in_ready = ~full_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/tdm_slot_mux.sv
// Time-division multiplexer: channel i may launch a word only while slot[i] is the active phase.
module tdm_slot_mux
  import ring_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned NCH = DefNch
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] slot,
  output logic           slot_err,
  tdm_slot_mux_if.slave  bus
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] hold_full;
  logic [NCH-1:0] clr;
  logic [DW-1:0]  hold_data [NCH];

  logic           slot_ok;
  logic           eligible;
  logic           handshake;
  logic           grant;
  logic [CW-1:0]  sel;

  state_e         state_q;
  logic           out_valid_q;
  logic [DW-1:0]  out_data_q;
  logic [CW-1:0]  out_chan_q;
  logic           slot_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_hold
    chan_hold #(
      .DW(DW)
    ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.in_valid[i]),
      .in_data  (bus.in_data[i*DW +: DW]),
      .in_ready (bus.in_ready[i]),
      .clr      (clr[i]),
      .full     (hold_full[i]),
      .data     (hold_data[i])
    );
  end

  // Slot decode and grant: a word launches in IDLE, or in SEND on the same edge as a handshake.
  always_comb begin
    slot_ok   = onehot_ok(32'(slot));
    sel       = CW'(onehot2bin(32'(slot)));
    eligible  = slot_ok && hold_full[sel];
    handshake = out_valid_q && bus.out_ready;
    grant     = eligible && ((state_q == StIdle) || handshake);
    clr       = '0;
    if (grant) clr[sel] = 1'b1;
  end

  // Output FSM with registered outputs; a stalled SEND ignores slot so no slot is borrowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      slot_err_q  <= 1'b0;
    end else begin
      if (!slot_ok) slot_err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            out_data_q  <= hold_data[sel];
            out_chan_q  <= sel;
            out_valid_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (handshake) begin
            if (grant) begin
              out_data_q <= hold_data[sel];
              out_chan_q <= sel;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign slot_err      = slot_err_q;

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Scoreboard bench for tdm_slot_mux with a bench-driven ring phase.
module tb_tdm_slot_mux;

  logic       clk;
  logic       rst;
  logic [3:0] slot;
  logic       slot_err;
  logic       ring_on;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sb_q[$];

  tdm_slot_mux_if #(.DW(8), .NCH(4)) bus_if ();

  tdm_slot_mux #(
    .DW  (8),
    .NCH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .slot     (slot),
    .slot_err (slot_err),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; then advance the ring 1000 -> 0100 -> 0010 -> 0001.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ring_on) slot = {slot[0], slot[3:1]};
  endtask

  task automatic wait_slot(input logic [3:0] target);
    int n;
    n = 0;
    while (slot !== target && n < 8) begin
      tick();
      n++;
    end
    check("wait_slot", 32'(slot), 32'(target));
  endtask

  // Monitor: a handshake will occur at the next posedge; compare against the scoreboard.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.out_valid && bus_if.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got chan %0d data %0h expected none",
                   bus_if.out_chan, bus_if.out_data);
        end else begin
          e = sb_q.pop_front();
          check("sb_word", 32'({bus_if.out_chan, bus_if.out_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    slot             = 4'b1000;
    ring_on          = 1'b1;
    bus_if.in_valid  = '0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;

    // Reset
    tick();
    tick();
    check("rst_in_ready", 32'(bus_if.in_ready), 32'hF);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("rst_out_data", 32'(bus_if.out_data), 32'h0);
    check("rst_out_chan", 32'(bus_if.out_chan), 32'h0);
    check("rst_slot_err", 32'(slot_err), 32'h0);
    rst = 1'b0;

    // Single word: ch2 loads during slot 1000, granted during slot 0100
    wait_slot(4'b1000);
    bus_if.in_valid[2]    = 1'b1;
    bus_if.in_data[16 +: 8] = 8'hA5;
    sb_q.push_back({2'd2, 8'hA5});
    tick();
    bus_if.in_valid = '0;
    check("single_captured_ready", 32'(bus_if.in_ready), 32'hB);
    check("single_not_yet_valid", 32'(bus_if.out_valid), 32'h0);
    tick();
    check("single_valid", 32'(bus_if.out_valid), 32'h1);
    check("single_chan", 32'(bus_if.out_chan), 32'h2);
    check("single_data", 32'(bus_if.out_data), 32'hA5);
    check("single_ready_back", 32'(bus_if.in_ready), 32'hF);
    tick();
    check("single_idle", 32'(bus_if.out_valid), 32'h0);

    // All four full: preload during slot 0001, drain 3,2,1,0 back-to-back
    wait_slot(4'b0001);
    bus_if.in_valid = 4'hF;
    bus_if.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    sb_q.push_back({2'd3, 8'h13});
    sb_q.push_back({2'd2, 8'h12});
    sb_q.push_back({2'd1, 8'h11});
    sb_q.push_back({2'd0, 8'h10});
    tick();
    bus_if.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("all_valid", 32'(bus_if.out_valid), 32'h1);
      check("all_chan", 32'(bus_if.out_chan), 32'(3 - k));
      check("all_data", 32'(bus_if.out_data), 32'(8'h13 - 8'(k)));
    end
    tick();
    check("all_drained", 32'(bus_if.out_valid), 32'h0);

    // Backpressure: ch3 granted and stalled 6 cycles; ch1 must wait for a fresh slot 0010
    wait_slot(4'b0001);
    bus_if.in_valid = 4'b1010;
    bus_if.in_data  = {8'h33, 8'h00, 8'h31, 8'h00};
    sb_q.push_back({2'd3, 8'h33});
    sb_q.push_back({2'd1, 8'h31});
    tick();
    bus_if.in_valid = '0;
    tick();
    check("bp_grant3", 32'(bus_if.out_valid), 32'h1);
    bus_if.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bp_stable", 32'({bus_if.out_valid, bus_if.out_chan, bus_if.out_data}),
            32'({1'b1, 2'd3, 8'h33}));
      check("bp_in_ready", 32'(bus_if.in_ready), 32'hD);
    end
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_wait_ch1", 32'(bus_if.out_valid), 32'h0);
    end
    tick();
    check("bp_ch1_valid", 32'(bus_if.out_valid), 32'h1);
    check("bp_ch1_chan", 32'(bus_if.out_chan), 32'h1);
    tick();
    check("bp_idle", 32'(bus_if.out_valid), 32'h0);

    // Bad slot: zero then multi-hot with ch3 full
    wait_slot(4'b0001);
    ring_on = 1'b0;
    bus_if.in_valid[3]      = 1'b1;
    bus_if.in_data[24 +: 8] = 8'h3C;
    sb_q.push_back({2'd3, 8'h3C});
    tick();
    bus_if.in_valid = '0;
    slot = 4'b0000;
    tick();
    check("bad0_err", 32'(slot_err), 32'h1);
    check("bad0_no_grant", 32'(bus_if.out_valid), 32'h0);
    check("bad0_held", 32'(bus_if.in_ready), 32'h7);
    slot = 4'b1100;
    tick();
    check("bad_multi_err", 32'(slot_err), 32'h1);
    check("bad_multi_no_grant", 32'(bus_if.out_valid), 32'h0);
    slot    = 4'b1000;
    ring_on = 1'b1;
    tick();
    check("bad_recover_valid", 32'(bus_if.out_valid), 32'h1);
    check("bad_recover_word", 32'({bus_if.out_chan, bus_if.out_data}), 32'({2'd3, 8'h3C}));
    tick();
    check("bad_once", 32'(bus_if.out_valid), 32'h0);
    check("bad_err_sticky", 32'(slot_err), 32'h1);

    // Refill: ch0 keeps in_valid high, data 01 then 02; grants one rotation apart
    wait_slot(4'b0100);
    bus_if.in_valid[0]    = 1'b1;
    bus_if.in_data[0 +: 8] = 8'h01;
    sb_q.push_back({2'd0, 8'h01});
    sb_q.push_back({2'd0, 8'h02});
    tick();
    bus_if.in_data[0 +: 8] = 8'h02;
    tick();
    check("refill_wait", 32'(bus_if.out_valid), 32'h0);
    tick();
    check("refill_first", 32'({bus_if.out_valid, bus_if.out_data}), 32'({1'b1, 8'h01}));
    check("refill_ready", 32'(bus_if.in_ready[0]), 32'h1);
    tick();
    bus_if.in_valid = '0;
    check("refill_captured", 32'(bus_if.in_ready[0]), 32'h0);
    check("refill_gap0", 32'(bus_if.out_valid), 32'h0);
    tick();
    check("refill_gap1", 32'(bus_if.out_valid), 32'h0);
    tick();
    check("refill_gap2", 32'(bus_if.out_valid), 32'h0);
    tick();
    check("refill_second", 32'({bus_if.out_valid, bus_if.out_data}), 32'({1'b1, 8'h02}));
    tick();
    check("refill_done", 32'(bus_if.out_valid), 32'h0);

    // Reset mid-SEND discards the stalled word
    wait_slot(4'b1000);
    bus_if.out_ready        = 1'b0;
    bus_if.in_valid[2]      = 1'b1;
    bus_if.in_data[16 +: 8] = 8'h77;
    tick();
    bus_if.in_valid = '0;
    tick();
    check("mid_send_valid", 32'(bus_if.out_valid), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus_if.out_valid), 32'h0);
    check("mid_rst_ready", 32'(bus_if.in_ready), 32'hF);
    check("mid_rst_err", 32'(slot_err), 32'h0);
    check("mid_rst_data", 32'(bus_if.out_data), 32'h0);
    rst              = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("mid_rst_gone", 32'(bus_if.out_valid), 32'h0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
